// File: rtl/intr_pkg.sv
// Shared state encoding and vector-address helper for the interrupt controller.
package intr_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_REQ     = REQ,
    S_SERVICE = SERVICE
  } state_t;

  // Vector address of a source; the caller truncates to its address width.
  function automatic logic [31:0] intr_vec(input logic [31:0] base,
                                           input logic [31:0] idx,
                                           input int unsigned shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt sources.
module intr_prio_enc #(
  parameter int unsigned N_INTR = 8,
  localparam int unsigned IDX_W = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
  input  logic [N_INTR-1:0] eligible,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  // Scan high to low so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    valid = |eligible;
    for (int i = int'(N_INTR) - 1; i >= 0; i--) begin
      if (eligible[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge detect, pending/mask registers, priority select
// and a req/ack/done handshake that blocks nesting until end of service.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int unsigned       N_INTR    = 8,
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE  = 10'b1111110000,
  parameter int unsigned       VEC_SHIFT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] intr_in,
  input  logic              mask_we,
  input  logic [N_INTR-1:0] mask_din,
  output logic [N_INTR-1:0] mask_out,
  output logic [N_INTR-1:0] pending_out,
  output logic              intr_req,
  output logic [ADDR_W-1:0] intr_dir_out,
  input  logic              intr_ack,
  input  logic              intr_done,
  output logic              busy
);

  localparam int unsigned IDX_W   = (N_INTR > 1) ? $clog2(N_INTR) : 1;
  localparam logic [63:0] VEC_TOP = 64'(VEC_BASE) + (64'(N_INTR - 1) << VEC_SHIFT);

  if (N_INTR < 1 || N_INTR > 32) begin : g_bad_n
    $error("intr_ctrl: N_INTR must be in 1..32");
  end
  if (VEC_TOP >= (64'd1 << ADDR_W)) begin : g_bad_vec
    $error("intr_ctrl: vector table does not fit in ADDR_W bits");
  end

  state_t              state, state_nxt;
  logic [N_INTR-1:0]   intr_prev, pending, mask;
  logic [N_INTR-1:0]   rise, eligible, clr, pending_nxt;
  logic                armed;
  logic [IDX_W-1:0]    idx_q, idx_nxt, enc_idx;
  logic                enc_valid;
  logic [ADDR_W-1:0]   dir_nxt;
  logic                req_nxt, busy_nxt;

  // armed stays low for the first cycle after reset so lines already high
  // at release are absorbed into intr_prev instead of firing.
  assign rise        = armed ? (intr_in & ~intr_prev) : '0;
  assign eligible    = pending & ~mask;
  assign pending_nxt = (pending & ~clr) | rise;
  assign mask_out    = mask;
  assign pending_out = pending;

  intr_prio_enc #(.N_INTR(N_INTR)) u_prio (
    .eligible (eligible),
    .idx      (enc_idx),
    .valid    (enc_valid)
  );

  // Datapath registers: edge history, pending and mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intr_prev <= '0;
      armed     <= 1'b0;
      pending   <= '0;
      mask      <= '0;
    end else begin
      intr_prev <= intr_in;
      armed     <= 1'b1;
      pending   <= pending_nxt;
      if (mask_we) mask <= mask_din;
    end
  end

  // FSM state and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      idx_q        <= '0;
      intr_req     <= 1'b0;
      busy         <= 1'b0;
      intr_dir_out <= VEC_BASE;
    end else begin
      state        <= state_nxt;
      idx_q        <= idx_nxt;
      intr_req     <= req_nxt;
      busy         <= busy_nxt;
      intr_dir_out <= dir_nxt;
    end
  end

  // Next-state logic; idx and vector only change on the IDLE -> REQ step.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    dir_nxt   = intr_dir_out;
    clr       = '0;
    case (state)
      S_IDLE: begin
        if (enc_valid) begin
          state_nxt = S_REQ;
          idx_nxt   = enc_idx;
          dir_nxt   = ADDR_W'(intr_vec(32'(VEC_BASE), 32'(enc_idx), VEC_SHIFT));
        end
      end
      S_REQ: begin
        if (intr_ack) begin
          clr       = N_INTR'(1) << idx_q;
          state_nxt = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (intr_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    req_nxt  = (state_nxt == S_REQ);
    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: default 8-source instance plus a 16-source variant.
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  intr_in, mask_din, mask_out, pending_out;
  logic        mask_we, intr_req, intr_ack, intr_done, busy;
  logic [9:0]  intr_dir_out;

  logic [15:0] intr_in16, mask_out16, pending_out16;
  logic        intr_req16, busy16;
  logic [11:0] intr_dir_out16;

  int passed = 0;
  int total  = 0;
  int req_seen;

  intr_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .intr_in      (intr_in),
    .mask_we      (mask_we),
    .mask_din     (mask_din),
    .mask_out     (mask_out),
    .pending_out  (pending_out),
    .intr_req     (intr_req),
    .intr_dir_out (intr_dir_out),
    .intr_ack     (intr_ack),
    .intr_done    (intr_done),
    .busy         (busy)
  );

  intr_ctrl #(
    .N_INTR    (16),
    .ADDR_W    (12),
    .VEC_BASE  (12'h800),
    .VEC_SHIFT (2)
  ) dut16 (
    .clk          (clk),
    .reset        (reset),
    .intr_in      (intr_in16),
    .mask_we      (1'b0),
    .mask_din     (16'h0000),
    .mask_out     (mask_out16),
    .pending_out  (pending_out16),
    .intr_req     (intr_req16),
    .intr_dir_out (intr_dir_out16),
    .intr_ack     (1'b0),
    .intr_done    (1'b0),
    .busy         (busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    intr_ack = 1'b1;
    step(1);
    intr_ack = 1'b0;
  endtask

  task automatic pulse_done();
    intr_done = 1'b1;
    step(1);
    intr_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; intr_in = '0; mask_we = 1'b0; mask_din = '0;
    intr_ack = 1'b0; intr_done = 1'b0; intr_in16 = '0;
    step(2);
    check("rst_req", 32'(intr_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pend", 32'(pending_out), 32'h0);
    check("rst_mask", 32'(mask_out), 32'h0);
    check("rst_dir", 32'(intr_dir_out), 32'h3F0);
    reset = 1'b0;
    step(2);

    // Single source, default parameters
    intr_in = 8'h08;
    step(1);
    check("s1_pend", 32'(pending_out), 32'h08);
    check("s1_req_early", 32'(intr_req), 32'h0);
    step(1);
    check("s1_req", 32'(intr_req), 32'h1);
    check("s1_dir", 32'(intr_dir_out), 32'h3F6);
    check("s1_busy", 32'(busy), 32'h1);
    step(3);
    check("s1_hold_req", 32'(intr_req), 32'h1);
    check("s1_hold_dir", 32'(intr_dir_out), 32'h3F6);
    pulse_ack();
    check("s1_ack_req", 32'(intr_req), 32'h0);
    check("s1_ack_pend", 32'(pending_out), 32'h00);
    check("s1_svc_busy", 32'(busy), 32'h1);
    pulse_done();
    check("s1_done_busy", 32'(busy), 32'h0);
    intr_in = 8'h00;
    step(2);

    // Priority between two simultaneous edges
    intr_in = 8'h24;
    step(1);
    check("p_pend", 32'(pending_out), 32'h24);
    step(1);
    check("p_dir1", 32'(intr_dir_out), 32'h3F4);
    pulse_ack();
    check("p_pend_ack", 32'(pending_out), 32'h20);
    pulse_done();
    check("p_req_after_done", 32'(intr_req), 32'h0);
    step(1);
    check("p_req2", 32'(intr_req), 32'h1);
    check("p_dir2", 32'(intr_dir_out), 32'h3FA);
    pulse_ack();
    pulse_done();
    check("p_pend_end", 32'(pending_out), 32'h00);
    intr_in = 8'h00;
    step(2);

    // Mask holds a pending source until unmasked
    mask_we = 1'b1; mask_din = 8'h01;
    step(1);
    mask_we = 1'b0;
    check("m_mask", 32'(mask_out), 32'h01);
    intr_in = 8'h01;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (intr_req) req_seen++;
    end
    check("m_no_req", 32'(req_seen), 32'h0);
    check("m_pend", 32'(pending_out), 32'h01);
    mask_we = 1'b1; mask_din = 8'h00;
    step(1);
    mask_we = 1'b0;
    step(1);
    check("m_req", 32'(intr_req), 32'h1);
    check("m_dir", 32'(intr_dir_out), 32'h3F0);
    pulse_ack();
    pulse_done();
    intr_in = 8'h00;
    step(2);

    // No nesting; re-arm of the serviced bit during the ack cycle
    intr_in = 8'h08;
    step(1);
    intr_in = 8'h00;
    step(1);
    check("n_dir", 32'(intr_dir_out), 32'h3F6);
    intr_in = 8'h08;
    pulse_ack();
    check("n_rearm_pend", 32'(pending_out), 32'h08);
    check("n_ack_req", 32'(intr_req), 32'h0);
    intr_in = 8'h0A;
    step(2);
    check("n_svc_no_req", 32'(intr_req), 32'h0);
    check("n_svc_pend", 32'(pending_out), 32'h0A);
    pulse_done();
    check("n_done_req", 32'(intr_req), 32'h0);
    step(1);
    check("n_req_b1", 32'(intr_req), 32'h1);
    check("n_dir_b1", 32'(intr_dir_out), 32'h3F2);
    pulse_ack();
    pulse_done();
    step(1);
    check("n_dir_b3", 32'(intr_dir_out), 32'h3F6);
    pulse_ack();
    pulse_done();
    intr_in = 8'h00;
    step(2);

    // Asynchronous reset while a request is outstanding
    intr_in = 8'h50;
    step(2);
    check("r_pre_dir", 32'(intr_dir_out), 32'h3F8);
    #2 reset = 1'b1;
    #1;
    check("r_req", 32'(intr_req), 32'h0);
    check("r_pend", 32'(pending_out), 32'h00);
    check("r_dir", 32'(intr_dir_out), 32'h3F0);
    check("r_busy", 32'(busy), 32'h0);
    step(1);
    reset = 1'b0;
    step(5);
    check("r_held_no_req", 32'(intr_req), 32'h0);
    check("r_held_no_pend", 32'(pending_out), 32'h00);
    intr_in = 8'h00;
    step(1);
    intr_in = 8'h10;
    step(2);
    check("r_rearm_dir", 32'(intr_dir_out), 32'h3F8);
    check("r_rearm_req", 32'(intr_req), 32'h1);

    // 16-source instance, top source
    intr_in16 = 16'h8000;
    step(2);
    check("w_req", 32'(intr_req16), 32'h1);
    check("w_dir", 32'(intr_dir_out16), 32'h83C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller that replaces the fixed 8-line combinational vector encoder in the CPU's interrupt path. It edge-detects N interrupt sources, latches them as pending, applies a software-writable mask, and selects the lowest-index unmasked pending source. It presents the selected vector address to the CPU through a request/acknowledge handshake and blocks further requests until the CPU signals end of service.

## Interface

Parameters:
- N_INTR, 8, number of interrupt sources (1..32)
- ADDR_W, 10, width of the vector address
- VEC_BASE, 10'b1111110000, vector address of source 0
- VEC_SHIFT, 1, log2 of the vector stride (stride 2 → 0x3F0, 0x3F2, …)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- intr_in  in  N_INTR  raw interrupt lines; a rising edge (sampled 0 then 1) raises a request
- mask_we  in  1  write strobe for the mask register
- mask_din  in  N_INTR  new mask value; bit = 1 disables that source
- mask_out  out  N_INTR  current mask register
- pending_out  out  N_INTR  current pending register
- intr_req  out  1  interrupt request to the CPU
- intr_dir_out  out  ADDR_W  vector address of the latched source
- intr_ack  in  1  CPU accepts the vector (single-cycle pulse)
- intr_done  in  1  CPU finished the ISR, e.g. on return-from-interrupt (single-cycle pulse)
- busy  out  1  high while in REQ or SERVICE

## Operation

- **Edge detect.** `intr_prev` registers `intr_in` every cycle. `edge = intr_in & ~intr_prev`. Each edge bit sets the matching pending bit.
- **Pending.**
  - A pending bit clears only on an accepted ack, and only for the latched index.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- **Mask.**
  - When `mask_we` is high, the mask loads `mask_din` at the clock edge.
  - Masking does not clear pending bits. A masked pending bit fires once it is unmasked.
- **Eligible sources.** `eligible = pending & ~mask`. Priority: lowest index wins.
- **Vector.** `VEC_BASE + (idx << VEC_SHIFT)`, truncated to ADDR_W bits. Elaboration fails if `VEC_BASE + ((N_INTR-1) << VEC_SHIFT) >= 2**ADDR_W`.
- **FSM states:** IDLE, REQ, SERVICE.
  - **IDLE:** if `eligible != 0`, latch `idx`, load `intr_dir_out`, and go to REQ. `intr_ack` and `intr_done` are ignored.
  - **REQ:** `intr_req = 1`. `idx` and `intr_dir_out` are frozen; mask writes and new edges do not retract or retarget the request. On `intr_ack`: clear `pending[idx]` and go to SERVICE. `intr_done` is ignored.
  - **SERVICE:** `intr_req = 0`, with no nesting. Edges and mask writes still update their registers. On `intr_done`, go to IDLE. `intr_ack` is ignored.
- **Simultaneous events.**
  - An `intr_done` and a new eligible source in the same cycle: the FSM returns to IDLE, and the new source is evaluated on the next cycle.
  - `intr_ack` and `intr_done` asserted together in REQ: only the ack is taken.
- **Reset** (asynchronous, any state, including mid-handshake):
  - state = IDLE
  - `intr_prev`, `pending`, `mask` = 0 (all sources enabled, matching legacy behaviour)
  - `intr_req` = 0, `busy` = 0
  - `intr_dir_out` = VEC_BASE
  - An in-flight request is lost. A line that is still high at reset release does not re-fire until it goes low and then high again.

## Timing

- All outputs are registered, except that `mask_out` and `pending_out` are direct register reads.
- Request latency:
  - `intr_in` is first sampled high at edge k, and `pending` is set after edge k.
  - The FSM enters REQ at edge k+1, so `intr_req` and `intr_dir_out` are valid after k+1.
  - Total: 2 cycles from the first high sample.
- Ack sampled at edge m with `intr_req = 1`: after edge m, `intr_req = 0` and the pending bit is cleared.
- `intr_done` sampled at edge d in SERVICE: the state is IDLE after edge d. The earliest next `intr_req` is after edge d+1.
- Handshake rules:
  - `intr_req` stays high with a stable `intr_dir_out` until it is acknowledged.
  - The CPU may hold off ack indefinitely.

## Structure

- **Package `intr_pkg`:**
  - state-encoding localparams: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2
  - function `intr_vec(base, idx, shift)` for the vector computation
- **Sub-module `intr_prio_enc`:** parametrised by N_INTR. Purely combinational. Input: `eligible`. Outputs: `idx` (`$clog2(N_INTR)` bits, minimum 1) and `valid`. Lowest index has priority.
- **Top level:** the edge and pending registers, the mask register, the FSM, and the output registers.

## Test plan

- **Single source, defaults.** Rising edge on `intr_in[3]`:
  - `intr_req` = 1 two cycles later, `intr_dir_out` = 10'b1111110110.
  - Ack: `intr_req` = 0, `pending_out[3]` = 0.
  - Done: `busy` = 0.
- **Priority.** Edges on bits 5 and 2 in the same cycle:
  - First vector = 0x3F4.
  - After ack/done, second vector = 0x3FA.
  - `pending_out` = 0 at the end.
- **Mask.** Write `mask` = 8'h01, then edge on bit 0: no `intr_req` for 10 cycles and `pending_out` = 8'h01. Write `mask` = 0: `intr_req` follows with vector 0x3F0.
- **No nesting / re-arm.**
  - In SERVICE, an edge on bit 1 produces no request.
  - After done, a request with 0x3F2 follows.
  - An edge on the serviced bit in the ack cycle leaves that bit pending.
- **Reset mid-operation.** Assert `reset` while in REQ:
  - Immediately `intr_req` = 0, `pending_out` = 0, `intr_dir_out` = 0x3F0.
  - A line held high across reset does not fire.
- **Parameters.** N_INTR=16, ADDR_W=12, VEC_BASE=12'h800, VEC_SHIFT=2: edge on bit 15 → vector 12'h83C.
